// File: rtl/imem_loader.sv
// Program loader and halt monitor: clears IM/DM, streams a program into IM while holding the
// CPU in reset, then releases the CPU and flags completion once the halt word has drained.
module imem_loader #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_BYTES = 128,
  parameter int unsigned HALT_DRAIN = 5
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [31:0]                   s_data_i,
  input  logic                          s_last_i,
  output logic                          im_we_o,
  output logic [$clog2(IMEM_DEPTH)-1:0] im_addr_o,
  output logic [31:0]                   im_wdata_o,
  output logic                          dm_we_o,
  output logic [$clog2(DMEM_BYTES)-1:0] dm_addr_o,
  output logic [7:0]                    dm_wdata_o,
  input  logic [31:0]                   fetch_instr_i,
  output logic                          cpu_rst_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          halted_o
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = $clog2(DMEM_BYTES);
  localparam int unsigned DW = (HALT_DRAIN > 0) ? $clog2(HALT_DRAIN + 1) : 1;
  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StRelease,
    StRun,
    StDrain,
    StHalted
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   wp_q, wp_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          err_q, err_d;
  logic          cpu_rst_q, busy_q, done_q, halted_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wp_d       = wp_q;
    drain_d    = drain_q;
    err_d      = err_q;
    s_ready_o  = 1'b0;
    im_we_o    = 1'b0;
    im_addr_o  = '0;
    im_wdata_o = '0;
    dm_we_o    = 1'b0;
    dm_addr_o  = '0;
    dm_wdata_o = '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StClear: begin
        dm_we_o   = 1'b1;
        dm_addr_o = cnt_q;
        if (32'(cnt_q) < IMEM_DEPTH) begin
          im_we_o   = 1'b1;
          im_addr_o = cnt_q[AW-1:0];
        end
        if (32'(cnt_q) == DMEM_BYTES - 1) begin
          state_d = StLoad;
          cnt_d   = '0;
          wp_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StLoad: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          if (32'(wp_q) < IMEM_DEPTH) begin
            im_we_o    = 1'b1;
            im_addr_o  = wp_q[AW-1:0];
            im_wdata_o = s_data_i;
            wp_d       = wp_q + 1'b1;
            if (s_last_i) state_d = StRelease;
          end else begin
            // Program longer than IM: drop the word and abort with the CPU still held.
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRelease: state_d = StRun;
      StRun: begin
        if (start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (fetch_instr_i == HaltWord) begin
          state_d = StDrain;
          drain_d = DW'(HALT_DRAIN);
        end
      end
      StDrain: begin
        if (start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (drain_q == '0) begin
          state_d = StHalted;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StHalted: begin
        if (start_i) begin
          state_d = StClear;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status flags are registered from the next state so they change on the same edge as it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wp_q      <= '0;
      drain_q   <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      cpu_rst_q <= state_d inside {StRun, StDrain, StHalted};
      busy_q    <= state_d inside {StClear, StLoad, StRelease};
      done_q    <= state_d inside {StRun, StDrain, StHalted};
      halted_q  <= (state_d == StHalted);
    end
  end

  assign cpu_rst_o = cpu_rst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign halted_o  = halted_q;

endmodule
